core_run_ctrl: RTL and testbench
================================

# core_run_ctrl

Synthesizable run controller that sits between the top level (or bench) and `core`. It sequences the core's reset and `go_contr` enable, then watches the core's instruction register output for a configurable halt sentinel. It also enforces a cycle-budget watchdog and reports run statistics. It generalises the fixed reset/go/stop-on-0xFFFFFFFF/timeout sequence into a reusable, parametrised, restartable block.

## Interface
Parameters:
- `IR_WIDTH`, 32, width of the monitored instruction register.
- `HALT_WORD`, 32'hFFFFFFFF, sentinel value that signals program end.
- `HALT_REPEAT`, 1, number of consecutive RUN cycles `ir_in` must equal `HALT_WORD` (≥1).
- `RST_CYCLES`, 2, cycles `core_reset` is held in RESET (≥1).
- `GO_DELAY`, 1, cycles between core reset release and `go_contr` assertion (≥1).
- `TIMEOUT`, 5000, maximum RUN cycles before watchdog expiry (≥1).
- `CNT_WIDTH`, 32, width of the statistics counters.

Ports:
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `abort` in 1: terminate the current sequence.
- `ir_in` in IR_WIDTH: the core's `irOut`.
- `core_reset` out 1: reset to the core.
- `go_contr` out 1: run enable to the core.
- `busy` out 1: high in RESET, ARM and RUN.
- `done` out 1: high in DONE.
- `status` out 2: 00 none, 01 halt, 10 timeout, 11 abort.
- `cycle_count` out CNT_WIDTH: RUN cycles elapsed, saturating.
- `ir_change_count` out CNT_WIDTH: RUN cycles where `ir_in` differed from the previous cycle's value, saturating.

## Operation
- States: IDLE, RESET, ARM, RUN, DONE. Outputs are registered or decoded from the state register only. There is no combinational input-to-output path.
- Reset (`reset`=1 at an edge), from any state: go to IDLE. Outputs become `core_reset`=1, `go_contr`=0, `busy`=0, `done`=0, `status`=00, both counters 0. Streak and sub-counters are cleared.
- IDLE: `core_reset`=1. If `start`=1, go to RESET, clear counters and status.
- RESET: `core_reset`=1 for exactly RST_CYCLES cycles, then go to ARM.
- ARM: `core_reset`=0, `go_contr`=0 for GO_DELAY cycles, then go to RUN. The last ARM edge loads `prev_ir` ← `ir_in`.
- RUN: `go_contr`=1. On each edge:
  - `cycle_count` +1 (saturate at all-ones).
  - `ir_change_count` +1 if `ir_in`≠`prev_ir`.
  - `prev_ir` ← `ir_in`.
  - `streak` ← (`ir_in`==HALT_WORD) ? `streak`+1 : 0.
- RUN exit conditions. Priority is abort > halt > timeout:
  - `abort`=1 → DONE, `status`=11.
  - New `streak` == HALT_REPEAT → DONE, `status`=01.
  - New `cycle_count` == TIMEOUT → DONE, `status`=10.
  - Counters are updated on the exiting edge as well.
- `abort`=1 in RESET or ARM → DONE, `status`=11, counters unchanged (0).
- DONE: `core_reset`=0 and `go_contr`=0, so core state is frozen for inspection. Counters and status hold. `start`=1 → RESET and clears counters and status. `abort` is ignored.
- `start` is ignored in RESET, ARM and RUN. `abort` is ignored in IDLE.

## Timing
- `start` sampled at edge k (IDLE) → `busy`=1 from k+1.
- `core_reset` falls at k+1+RST_CYCLES.
- `go_contr` rises at k+1+RST_CYCLES+GO_DELAY.
- Halt/timeout/abort sampled at edge m → `go_contr`=0, `done`=1, `status` valid from m+1. Counters are final at m+1.
- Sentinel present on RUN cycles 1..n, with HALT_REPEAT=1 and the first RUN edge counted as 1: `cycle_count` final = index of the first sentinel cycle.
- Timeout: DONE with `cycle_count`==TIMEOUT exactly.
- `reset` mid-RUN → IDLE values at the next edge. `go_contr` drops in the same cycle that `core_reset` rises.

## Test plan
- Normal halt (defaults): `start` at edge 0, `ir_in`=0x00000013 for 10 RUN cycles, then 0xFFFFFFFF. Required: `core_reset` high through edge 2, `go_contr` rises at edge 4, then `done`=1, `status`=01, `cycle_count`=11, `ir_change_count`=1 (0x13 loaded at the last ARM edge).
- Timeout (TIMEOUT=20): `ir_in` never equals HALT_WORD. Required: `status`=10, `cycle_count`=20, `go_contr` high for exactly 20 cycles.
- Debounce (HALT_REPEAT=3): sentinel for 2 cycles, 1 non-sentinel, then 3 sentinels. Required: no exit after the first pair; `status`=01 after the third consecutive sentinel.
- Abort: `abort` in ARM → `status`=11, `go_contr` never asserted, `cycle_count`=0. `abort` on the same RUN edge as the final sentinel → `status`=11.
- Restart/ignore: `start` pulsed in RUN has no effect. `start` in DONE → counters and `status` cleared, full RESET/ARM sequence repeats with identical timing.
- Mid-run reset: `reset` at RUN cycle 7. Required: next cycle `core_reset`=1, `go_contr`=0, `busy`=0, counters 0, `status`=00.

Source files
------------

// File: rtl/core_run_ctrl.sv
// Run controller for the core: sequences reset and go, then watches irOut
// for a halt sentinel under a cycle-budget watchdog and keeps run statistics.
module core_run_ctrl #(
    parameter int unsigned                IR_WIDTH    = 32,
    parameter logic [IR_WIDTH-1:0]        HALT_WORD   = {IR_WIDTH{1'b1}},
    parameter int unsigned                HALT_REPEAT = 1,
    parameter int unsigned                RST_CYCLES  = 2,
    parameter int unsigned                GO_DELAY    = 1,
    parameter int unsigned                TIMEOUT     = 5000,
    parameter int unsigned                CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [IR_WIDTH-1:0]  ir_in,
    output logic                 core_reset,
    output logic                 go_contr,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] ir_change_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALT    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    state_t                state_q;
    logic [31:0]           sub_q;
    logic [31:0]           streak_q;
    logic [IR_WIDTH-1:0]   prev_q;
    logic [CNT_WIDTH-1:0]  cyc_q;
    logic [CNT_WIDTH-1:0]  chg_q;
    logic [1:0]            status_q;
    logic                  core_reset_q;
    logic                  go_q;
    logic                  busy_q;
    logic                  done_q;

    logic [CNT_WIDTH-1:0]  cyc_d;
    logic [CNT_WIDTH-1:0]  chg_d;
    logic [31:0]           streak_d;
    logic                  halt_hit;
    logic                  tmo_hit;

    always_comb begin
        cyc_d    = cyc_q;
        chg_d    = chg_q;
        streak_d = '0;
        if (cyc_q != '1) begin
            cyc_d = cyc_q + CNT_WIDTH'(1);
        end
        if ((ir_in != prev_q) && (chg_q != '1)) begin
            chg_d = chg_q + CNT_WIDTH'(1);
        end
        if (ir_in == HALT_WORD) begin
            streak_d = streak_q + 32'd1;
        end
        halt_hit = (streak_d == 32'(HALT_REPEAT));
        tmo_hit  = (cyc_d == CNT_WIDTH'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sub_q        <= '0;
            streak_q     <= '0;
            prev_q       <= '0;
            cyc_q        <= '0;
            chg_q        <= '0;
            status_q     <= ST_NONE;
            core_reset_q <= 1'b1;
            go_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_RESET;
                        sub_q        <= '0;
                        streak_q     <= '0;
                        cyc_q        <= '0;
                        chg_q        <= '0;
                        status_q     <= ST_NONE;
                        core_reset_q <= 1'b1;
                        go_q         <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (abort) begin
                        state_q      <= S_DONE;
                        status_q     <= ST_ABORT;
                        core_reset_q <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end else if (sub_q == 32'(RST_CYCLES - 1)) begin
                        state_q      <= S_ARM;
                        sub_q        <= '0;
                        core_reset_q <= 1'b0;
                    end else begin
                        sub_q <= sub_q + 32'd1;
                    end
                end
                S_ARM: begin
                    // Seed the change detector with the value present at go.
                    prev_q <= ir_in;
                    if (abort) begin
                        state_q  <= S_DONE;
                        status_q <= ST_ABORT;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (sub_q == 32'(GO_DELAY - 1)) begin
                        state_q  <= S_RUN;
                        sub_q    <= '0;
                        streak_q <= '0;
                        go_q     <= 1'b1;
                    end else begin
                        sub_q <= sub_q + 32'd1;
                    end
                end
                S_RUN: begin
                    cyc_q    <= cyc_d;
                    chg_q    <= chg_d;
                    prev_q   <= ir_in;
                    streak_q <= streak_d;
                    if (abort || halt_hit || tmo_hit) begin
                        state_q <= S_DONE;
                        go_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (abort) begin
                            status_q <= ST_ABORT;
                        end else if (halt_hit) begin
                            status_q <= ST_HALT;
                        end else begin
                            status_q <= ST_TIMEOUT;
                        end
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    core_reset_q <= 1'b1;
                    go_q         <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign core_reset      = core_reset_q;
    assign go_contr        = go_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign status          = status_q;
    assign cycle_count     = cyc_q;
    assign ir_change_count = chg_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: two instances (single halt word with short
// watchdog, and three-word debounce), scoreboard of expected run results.
module tb_core_run_ctrl;

    localparam logic [31:0] HW = 32'hFFFFFFFF;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] cyc;
        logic [31:0] chg;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        st    [2];
    logic        ab    [2];
    logic [31:0] ir    [2];
    logic        cr    [2];
    logic        go    [2];
    logic        bz    [2];
    logic        dn    [2];
    logic [1:0]  stt   [2];
    logic [31:0] cc    [2];
    logic [31:0] ic    [2];

    int          hr    [2];
    int          to    [2];
    exp_t        exp_q [$];
    logic [31:0] stim_q[$];
    int          passed;
    int          total;

    core_run_ctrl #(
        .HALT_REPEAT (1),
        .TIMEOUT     (20)
    ) u_a (
        .clk             (clk),
        .reset           (rst),
        .start           (st[0]),
        .abort           (ab[0]),
        .ir_in           (ir[0]),
        .core_reset      (cr[0]),
        .go_contr        (go[0]),
        .busy            (bz[0]),
        .done            (dn[0]),
        .status          (stt[0]),
        .cycle_count     (cc[0]),
        .ir_change_count (ic[0])
    );

    core_run_ctrl #(
        .HALT_REPEAT (3)
    ) u_b (
        .clk             (clk),
        .reset           (rst),
        .start           (st[1]),
        .abort           (ab[1]),
        .ir_in           (ir[1]),
        .core_reset      (cr[1]),
        .go_contr        (go[1]),
        .busy            (bz[1]),
        .done            (dn[1]),
        .status          (stt[1]),
        .cycle_count     (cc[1]),
        .ir_change_count (ic[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (cr[d] !== 1'b1 || go[d] !== 1'b0 || bz[d] !== 1'b0 ||
                dn[d] !== 1'b0 || stt[d] !== 2'b00 || cc[d] !== 32'd0 ||
                ic[d] !== 32'd0) begin
                $display("FAIL reset[%0d]: cr=%b go=%b busy=%b done=%b st=%b cc=%0d ic=%0d, want 1 0 0 0 00 0 0",
                         d, cr[d], go[d], bz[d], dn[d], stt[d], cc[d], ic[d]);
            end else begin
                passed++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic start_seq(input int d, input string nm);
        ir[d] = stim_q[0];
        st[d] = 1'b1;
        step();
        st[d] = 1'b0;
        total++;
        if (bz[d] !== 1'b1 || cr[d] !== 1'b1 || go[d] !== 1'b0 ||
            dn[d] !== 1'b0 || stt[d] !== 2'b00 || cc[d] !== 32'd0 ||
            ic[d] !== 32'd0) begin
            $display("FAIL %s start: busy=%b cr=%b go=%b done=%b st=%b cc=%0d ic=%0d, want 1 1 0 0 00 0 0",
                     nm, bz[d], cr[d], go[d], dn[d], stt[d], cc[d], ic[d]);
        end else begin
            passed++;
        end
        step();
        total++;
        if (cr[d] !== 1'b1 || go[d] !== 1'b0) begin
            $display("FAIL %s reset2: cr=%b go=%b, want 1 0", nm, cr[d], go[d]);
        end else begin
            passed++;
        end
        step();
        total++;
        if (cr[d] !== 1'b0 || go[d] !== 1'b0 || bz[d] !== 1'b1) begin
            $display("FAIL %s arm: cr=%b go=%b busy=%b, want 0 0 1",
                     nm, cr[d], go[d], bz[d]);
        end else begin
            passed++;
        end
    endtask

    task automatic run(input int d, input string nm, input int abort_at,
                       input int start_at, input int reset_at);
        int          cyc;
        int          chg;
        int          streak;
        int          gocnt;
        logic [31:0] prev;
        logic [31:0] v;
        logic [1:0]  est;
        bit          ex;
        exp_t        e;
        cyc    = 0;
        chg    = 0;
        streak = 0;
        ex     = 1'b0;
        start_seq(d, nm);
        prev = ir[d];
        step();
        total++;
        if (go[d] !== 1'b1 || cr[d] !== 1'b0) begin
            $display("FAIL %s go_rise: go=%b cr=%b, want 1 0", nm, go[d], cr[d]);
        end else begin
            passed++;
        end
        gocnt = 1;
        for (int i = 1; i <= 100 && !ex; i++) begin
            v     = (i - 1 < stim_q.size()) ? stim_q[i-1] : stim_q[$];
            ir[d] = v;
            ab[d] = (i == abort_at);
            st[d] = (i == start_at);
            if (i == reset_at) begin
                rst = 1'b1;
                step();
                rst   = 1'b0;
                st[d] = 1'b0;
                ab[d] = 1'b0;
                total++;
                if (cr[d] !== 1'b1 || go[d] !== 1'b0 || bz[d] !== 1'b0 ||
                    dn[d] !== 1'b0 || stt[d] !== 2'b00 || cc[d] !== 32'd0 ||
                    ic[d] !== 32'd0) begin
                    $display("FAIL %s midreset: cr=%b go=%b busy=%b done=%b st=%b cc=%0d ic=%0d, want 1 0 0 0 00 0 0",
                             nm, cr[d], go[d], bz[d], dn[d], stt[d], cc[d], ic[d]);
                end else begin
                    passed++;
                end
                return;
            end
            cyc++;
            if (v !== prev) chg++;
            prev   = v;
            streak = (v == HW) ? streak + 1 : 0;
            est    = 2'b00;
            if (i == abort_at)       est = 2'b11;
            else if (streak == hr[d]) est = 2'b01;
            else if (cyc == to[d])    est = 2'b10;
            if (est != 2'b00) begin
                ex = 1'b1;
                exp_q.push_back('{est, 32'(cyc), 32'(chg)});
            end
            step();
            ab[d] = 1'b0;
            st[d] = 1'b0;
            if (!ex) begin
                if (go[d] === 1'b1 && dn[d] === 1'b0) begin
                    gocnt++;
                end else begin
                    total++;
                    $display("FAIL %s early_exit: cycle=%0d go=%b done=%b st=%b, want go=1 done=0",
                             nm, i, go[d], dn[d], stt[d]);
                    return;
                end
            end
        end
        total++;
        if (dn[d] !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL %s done_bound: done=%b queued=%0d, want done=1",
                     nm, dn[d], exp_q.size());
            return;
        end
        passed++;
        e = exp_q.pop_front();
        total++;
        if (stt[d] !== e.st) begin
            $display("FAIL %s status: got %b want %b", nm, stt[d], e.st);
        end else begin
            passed++;
        end
        total++;
        if (cc[d] !== e.cyc || ic[d] !== e.chg) begin
            $display("FAIL %s counts: cc=%0d ic=%0d want cc=%0d ic=%0d",
                     nm, cc[d], ic[d], e.cyc, e.chg);
        end else begin
            passed++;
        end
        total++;
        if (go[d] !== 1'b0 || cr[d] !== 1'b0 || bz[d] !== 1'b0 ||
            32'(gocnt) !== e.cyc) begin
            $display("FAIL %s done_outs: go=%b cr=%b busy=%b go_cycles=%0d, want 0 0 0 %0d",
                     nm, go[d], cr[d], bz[d], gocnt, e.cyc);
        end else begin
            passed++;
        end
    endtask

    task automatic test_halt();
        stim_q.delete();
        repeat (10) stim_q.push_back(32'h13);
        stim_q.push_back(HW);
        run(0, "halt", 0, 0, 0);
    endtask

    task automatic test_restart_ignore();
        stim_q.delete();
        for (int i = 0; i < 6; i++) stim_q.push_back(32'h40 + 32'(i % 2));
        stim_q.push_back(HW);
        run(0, "restart", 0, 3, 0);
    endtask

    task automatic test_timeout();
        stim_q.delete();
        for (int i = 0; i < 30; i++) stim_q.push_back(32'(i % 3));
        run(0, "timeout", 0, 0, 0);
    endtask

    task automatic test_abort_arm();
        stim_q.delete();
        stim_q.push_back(32'h13);
        start_seq(0, "abort_arm");
        ab[0] = 1'b1;
        step();
        ab[0] = 1'b0;
        total++;
        if (dn[0] !== 1'b1 || stt[0] !== 2'b11 || go[0] !== 1'b0 ||
            cr[0] !== 1'b0 || cc[0] !== 32'd0 || ic[0] !== 32'd0) begin
            $display("FAIL abort_arm: done=%b st=%b go=%b cr=%b cc=%0d ic=%0d, want 1 11 0 0 0 0",
                     dn[0], stt[0], go[0], cr[0], cc[0], ic[0]);
        end else begin
            passed++;
        end
        step();
        total++;
        if (go[0] !== 1'b0 || dn[0] !== 1'b1) begin
            $display("FAIL abort_arm_hold: go=%b done=%b, want 0 1", go[0], dn[0]);
        end else begin
            passed++;
        end
    endtask

    task automatic test_abort_halt();
        stim_q.delete();
        repeat (5) stim_q.push_back(32'h13);
        stim_q.push_back(HW);
        run(0, "abort_halt", 6, 0, 0);
    endtask

    task automatic test_debounce();
        stim_q.delete();
        stim_q.push_back(32'h13);
        stim_q.push_back(32'h13);
        stim_q.push_back(HW);
        stim_q.push_back(HW);
        stim_q.push_back(32'h13);
        stim_q.push_back(HW);
        stim_q.push_back(HW);
        stim_q.push_back(HW);
        run(1, "debounce", 0, 0, 0);
    endtask

    task automatic test_mid_reset();
        stim_q.delete();
        for (int i = 0; i < 20; i++) stim_q.push_back(32'h100 + 32'(i));
        run(0, "mid_reset", 0, 0, 7);
    endtask

    task automatic test_back_to_back();
        stim_q.delete();
        stim_q.push_back(32'h7);
        stim_q.push_back(32'h8);
        stim_q.push_back(HW);
        run(0, "b2b", 0, 0, 0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        hr[0]  = 1;
        hr[1]  = 3;
        to[0]  = 20;
        to[1]  = 5000;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0;
            ab[d] = 1'b0;
            ir[d] = 32'h0;
        end
        test_reset();
        test_halt();
        test_restart_ignore();
        test_timeout();
        test_abort_arm();
        test_abort_halt();
        test_debounce();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
